// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select, continuous round-robin
// scan and single-sweep modes; output is a valid/ready stream tagged with the channel.
module mux_scan_n #(
  parameter int NCH   = 8,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*W-1:0]   in_data,
  input  logic [SELW-1:0]    sel,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [NCH-1:0]     ch_mask,
  output logic [W-1:0]       out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sweep_done,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_SCAN   = 2'b01;
  localparam logic [1:0] M_SWEEP  = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD, S_DWELL} state_t;

  // Stream handshake: a beat transfers in any cycle where out_valid & out_ready.
  // While out_valid & !out_ready, out_data/out_ch are frozen; out_valid never drops
  // without an acceptance except on reset.

  state_t            state_q;
  logic [SELW-1:0]   ptr_q;
  logic [CW-1:0]     dwell_q;
  logic [W-1:0]      out_data_q;
  logic [SELW-1:0]   out_ch_q;
  logic              out_valid_q;
  logic              sweep_done_q;

  logic              reg_free_d;
  logic              accept_d;
  logic              mask_any_d;
  logic [SELW-1:0]   nxt_ptr_d;
  logic [SELW-1:0]   first_ptr_d;
  logic [W-1:0]      sel_data_d;
  logic [W-1:0]      ptr_data_d;

  // First enabled channel strictly after p, wrapping; returns p when the mask is empty.
  function automatic logic [SELW-1:0] nxt_of(input logic [SELW-1:0] p,
                                             input logic [NCH-1:0]  m);
    logic [SELW-1:0] r;
    logic            found;
    int              idx;
    r     = p;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(p) + i) % NCH;
      if (!found && m[idx]) begin
        r     = SELW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    reg_free_d  = !out_valid_q || out_ready;
    accept_d    = out_valid_q && out_ready;
    mask_any_d  = |ch_mask;
    nxt_ptr_d   = nxt_of(ptr_q, ch_mask);
    first_ptr_d = nxt_of(SELW'(NCH - 1), ch_mask);
    sel_data_d  = '0;
    ptr_data_d  = '0;
    // Out-of-range selects fall through to zero data.
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k))   sel_data_d = in_data[k*W +: W];
      if (ptr_q == SELW'(k)) ptr_data_d = in_data[k*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      dwell_q      <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      if (reg_free_d) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mask_any_d && (mode == M_SCAN || (mode == M_SWEEP && start))) begin
            ptr_q   <= first_ptr_d;
            state_q <= S_CAPTURE;
          end else if (mode == M_MANUAL && reg_free_d) begin
            out_data_q  <= sel_data_d;
            out_ch_q    <= sel;
            out_valid_q <= 1'b1;
          end
        end
        S_CAPTURE: begin
          // Waits here if a manual beat is still pending when a scan starts.
          if (reg_free_d) begin
            out_data_q  <= ptr_data_d;
            out_ch_q    <= ptr_q;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept_d) begin
            if (mode == M_SWEEP && mask_any_d && nxt_ptr_d <= ptr_q) begin
              sweep_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else if (!mask_any_d || mode == M_MANUAL || mode == M_HOLD) begin
              state_q <= S_IDLE;
            end else begin
              ptr_q <= nxt_ptr_d;
              if (DWELL == 0) begin
                state_q <= S_CAPTURE;
              end else begin
                dwell_q <= CW'(DWELL);
                state_q <= S_DWELL;
              end
            end
          end
        end
        S_DWELL: begin
          dwell_q <= dwell_q - 1'b1;
          if (dwell_q <= CW'(1)) state_q <= S_CAPTURE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign sweep_done = sweep_done_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: expected beats are queued by the driver and popped
// by a monitor on every accepted beat; timing properties are checked inline.
module tb_mux_scan_n;

  localparam int NCH  = 8;
  localparam int W    = 8;
  localparam int SELW = 3;
  localparam int NCH1 = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance: NCH=8, W=8, DWELL=2
  logic [NCH*W-1:0] in_data;
  logic [SELW-1:0]  sel;
  logic [1:0]       mode;
  logic             start;
  logic [NCH-1:0]   ch_mask;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_valid;
  logic             out_ready;
  logic             sweep_done;
  logic             busy;
  logic [1:0]       dbg_state;

  // second instance: NCH=5, W=8, DWELL=0
  logic [NCH1*W-1:0] in_data1;
  logic [2:0]        sel1;
  logic [1:0]        mode1;
  logic              start1;
  logic [NCH1-1:0]   ch_mask1;
  logic [W-1:0]      out_data1;
  logic [2:0]        out_ch1;
  logic              out_valid1;
  logic              out_ready1;
  logic              sweep_done1;
  logic              busy1;
  logic [1:0]        dbg_state1;

  mux_scan_n #(.NCH(NCH), .W(W), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode), .start(start),
    .ch_mask(ch_mask), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .sweep_done(sweep_done), .busy(busy), .dbg_state(dbg_state)
  );

  mux_scan_n #(.NCH(NCH1), .W(W), .DWELL(0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .sel(sel1), .mode(mode1), .start(start1),
    .ch_mask(ch_mask1), .out_data(out_data1), .out_ch(out_ch1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sweep_done(sweep_done1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [SELW+W-1:0] exp_q[$];
  logic [SELW+W-1:0] exp_e;

  task automatic push_beat(input int ch);
    logic [7:0] d;
    d = 8'h10 + 8'(ch);
    exp_q.push_back({3'(ch), d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got ch=%0d data=%02h, no beat expected", out_ch, out_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({out_ch, out_data} !== exp_e) begin
          fails++;
          $display("FAIL sb_beat: got ch=%0d data=%02h expected ch=%0d data=%02h",
                   out_ch, out_data, exp_e[10:8], exp_e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   cyc;
    int   rises;
    int   t[6];
    int   chs[4];
    int   sd_cnt;
    logic pv;
    logic seen;
    logic acc;
    logic sd_ok;

    for (int k = 0; k < NCH; k++)  in_data[k*W +: W]  = 8'h10 + 8'(k);
    for (int k = 0; k < NCH1; k++) in_data1[k*W +: W] = 8'h20 + 8'(k);
    sel = '0; mode = 2'b11; start = 0; ch_mask = '0; out_ready = 1;
    sel1 = '0; mode1 = 2'b11; start1 = 0; ch_mask1 = '0; out_ready1 = 1;
    for (int i = 0; i < 6; i++) t[i] = 0;

    // reset state
    tick(); tick();
    check("reset_outputs", 32'({out_valid, out_ch, out_data, sweep_done, busy}), 32'd0);
    rst = 0;
    tick(); tick();
    check("hold_mode_idle", 32'({out_valid, busy}), 32'd0);

    // manual mode, latency 1
    mode = 2'b00; sel = 3'd5; push_beat(5);
    tick();
    check("manual_sel5", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 3'd5, 8'h15}));
    sel = 3'd2; push_beat(2);
    tick();
    check("manual_sel2", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 3'd2, 8'h12}));
    mode = 2'b11;
    tick();
    check("manual_stop", 32'(out_valid), 32'd0);

    // continuous scan, mask A5, DWELL=2
    ch_mask = 8'hA5; mode = 2'b01;
    push_beat(0); push_beat(2); push_beat(5); push_beat(7); push_beat(0); push_beat(2);
    rises = 0; cyc = 0; pv = out_valid;
    while (rises < 6 && cyc < 80) begin
      tick(); cyc++;
      if (out_valid && !pv) begin t[rises] = cyc; rises++; end
      pv = out_valid;
    end
    mode = 2'b11;
    check("scan_rises", 32'(rises), 32'd6);
    for (int i = 1; i < 6; i++) check("scan_spacing", 32'(t[i] - t[i-1]), 32'd4);
    tick(); tick(); tick();
    check("scan_stop_idle", 32'({busy, out_valid}), 32'd0);

    // backpressure at channel 2
    mode = 2'b01; push_beat(0); push_beat(2);
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      tick(); cyc++;
      if (out_valid && out_ch == 3'd2) seen = 1;
    end
    out_ready = 0;
    check("bp_reach_ch2", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", 32'({out_valid, out_ch, out_data, busy}), 32'({1'b1, 3'd2, 8'h12, 1'b1}));
    end
    push_beat(5); out_ready = 1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      tick(); cyc++;
      if (out_valid && out_ch == 3'd5) seen = 1;
    end
    mode = 2'b11;
    check("bp_resume_ch5", 32'(seen), 32'd1);
    tick(); tick(); tick();

    // single sweep, mask 06
    mode = 2'b10; ch_mask = 8'h06; push_beat(1); push_beat(2);
    start = 1;
    tick();
    start = 0;
    check("sweep_busy", 32'(busy), 32'd1);
    sd_cnt = 0; sd_ok = 0;
    for (int i = 0; i < 30; i++) begin
      acc = out_valid && out_ready && (out_ch == 3'd2);
      tick();
      if (sweep_done) begin
        sd_cnt++;
        if (acc) sd_ok = 1;
      end
    end
    check("sweep_done_count", 32'(sd_cnt), 32'd1);
    check("sweep_done_adjacent", 32'(sd_ok), 32'd1);
    check("sweep_end_idle", 32'({busy, out_valid}), 32'd0);

    // mask cleared during DWELL
    mode = 2'b01; ch_mask = 8'hA5; push_beat(0); push_beat(2);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      if (out_valid) seen = 1;
    end
    check("mclr_first_beat", 32'(seen), 32'd1);
    tick();
    ch_mask = '0;
    sd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sweep_done) sd_cnt++;
    end
    check("mclr_no_sweep_done", 32'(sd_cnt), 32'd0);
    check("mclr_idle_mask0", 32'({busy, out_valid}), 32'd0);
    check("mclr_queue_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-beat
    out_ready = 0; ch_mask = 8'hA5;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      if (out_valid) seen = 1;
    end
    check("rst_pending_beat", 32'(seen), 32'd1);
    #1 rst = 1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", 32'({out_ch, out_data}), 32'd0);
    check("rst_async_flags", 32'({busy, sweep_done}), 32'd0);
    mode = 2'b00; sel = 3'd0; out_ready = 1; ch_mask = '0;
    #1 rst = 0;
    push_beat(0);
    tick();
    check("rst_first_beat", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 3'd0, 8'h10}));
    mode = 2'b11;
    tick(); tick();

    // NCH=5 instance: out-of-range select and DWELL=0 scan
    mode1 = 2'b00; sel1 = 3'd6;
    tick();
    check("n5_sel6", 32'({out_valid1, out_ch1, out_data1}), 32'({1'b1, 3'd6, 8'h00}));
    sel1 = 3'd3;
    tick();
    check("n5_sel3", 32'({out_valid1, out_ch1, out_data1}), 32'({1'b1, 3'd3, 8'h23}));
    mode1 = 2'b11;
    tick(); tick();
    mode1 = 2'b01; ch_mask1 = 5'b10010;
    rises = 0; cyc = 0; pv = out_valid1;
    while (rises < 4 && cyc < 40) begin
      tick(); cyc++;
      if (out_valid1 && !pv) begin t[rises] = cyc; chs[rises] = int'(out_ch1); rises++; end
      pv = out_valid1;
    end
    mode1 = 2'b11;
    check("n5_scan_rises", 32'(rises), 32'd4);
    for (int i = 1; i < 4; i++) check("n5_scan_spacing", 32'(t[i] - t[i-1]), 32'd2);
    check("n5_scan_ch0", 32'(chs[0]), 32'd1);
    check("n5_scan_ch1", 32'(chs[1]), 32'd4);
    check("n5_scan_ch2", 32'(chs[2]), 32'd1);
    tick(); tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
Parametrised N-channel, W-bit registered multiplexer. It succeeds the fixed 8:1 single-bit gate-level mux. Three operating modes:
- manual selection, like the combinational mux;
- continuous round-robin scan over an enable mask;
- single sweep triggered by a start pulse.
Output is a registered valid/ready stream tagged with the channel index. It sits between parallel sample sources and a single serial consumer.

Parameters:
NCH, 8, number of input channels (>=2, need not be a power of two)
W, 8, data width per channel
SELW, $clog2(NCH), width of select and channel-index fields (derived; not overridden)
DWELL, 4, idle cycles between accepted beat and next capture in scan modes (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  NCH*W  channel k occupies bits [k*W +: W]
sel  in  SELW  channel select, manual mode
mode  in  2  00 manual, 01 continuous scan, 10 single sweep, 11 hold
start  in  1  single-cycle pulse; starts a sweep in mode 10
ch_mask  in  NCH  1 = channel enabled for scan modes
out_data  out  W  registered selected data
out_ch  out  SELW  channel index of out_data
out_valid  out  1  out_data/out_ch valid
out_ready  in  1  consumer accepts when out_valid & out_ready
sweep_done  out  1  one-cycle pulse after the last beat of a sweep is accepted
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, any time, including mid-beat): out_data=0, out_ch=0, out_valid=0, sweep_done=0, busy=0, FSM=IDLE, ptr=0, dwell counter=0. A pending beat is discarded.
- Output register is "free" when !out_valid or (out_valid & out_ready). Data and channel are held stable while out_valid & !out_ready.
- Manual mode (mode=00, FSM IDLE): every cycle the register is free, it loads out_data=in_data[sel], out_ch=sel, out_valid=1.
  - Latency: 1 cycle.
  - With out_ready=1, one beat per cycle.
  - sel>=NCH: out_data=0, out_ch=sel, still valid.
- Hold mode (11): no new loads; a pending beat still completes.
- nxt(p): first index q in p+1, p+2, ... (modulo NCH) with ch_mask[q]=1, evaluated on the current-cycle mask. first() = nxt(NCH-1), i.e. the search starts at 0.
- Scan FSM states: IDLE, CAPTURE, HOLD, DWELL.
  - IDLE -> CAPTURE, ptr=first(), when mask!=0 and either mode=01, or mode=10 with start=1.
  - CAPTURE (1 cycle): out_data=in_data[ptr], out_ch=ptr, out_valid=1 -> HOLD.
  - HOLD: wait for out_ready. On acceptance, out_valid=0, then:
    - mode=10 and nxt(ptr)<=ptr (wrapped, sweep complete): sweep_done=1 for 1 cycle, -> IDLE.
    - mask==0, or mode is now 00/11: -> IDLE, no sweep_done.
    - otherwise: ptr=nxt(ptr), load dwell counter=DWELL, -> DWELL (-> CAPTURE directly if DWELL=0).
  - DWELL: decrement; at 1 -> CAPTURE.
- Beat spacing in scan modes with out_ready held high: DWELL+2 cycles.
- Mode changes take effect only at IDLE or on HOLD exit. A valid beat is never dropped or altered.
- start is ignored when not in IDLE or mode!=10.
- Mask zero in IDLE: remains IDLE, busy=0, no output.
- A single enabled channel in continuous mode repeats that channel.
- sweep_done and acceptance of the final beat are in adjacent cycles; sweep_done is registered.

Test Plan:
- Reset: hold rst=1 mid-scan with out_valid=1 -> all outputs 0 asynchronously; after release with mode=00, sel=0, first beat appears 1 cycle later.
- Manual: NCH=8, W=8, channel k data=0x10+k, sel=5, out_ready=1 -> out_data=0x15, out_ch=5 one cycle after sel is applied. Changing sel to 2 -> 0x12 next cycle.
- Continuous scan: mask=8'b1010_0101, DWELL=2, out_ready=1 -> out_ch sequence 0,2,5,7,0,2, with out_valid rising every 4 cycles.
- Backpressure: continuous scan with out_ready=0 for 10 cycles at ch 2 -> out_valid, out_data=0x12 and out_ch=2 held stable; no advance until out_ready=1.
- Single sweep: mode=10, mask=8'b0000_0110, start pulse -> beats ch 1 then ch 2; sweep_done high exactly 1 cycle after ch 2 is accepted; busy=0 afterwards; no further beats without start.
- Mask edge cases:
  - Clear mask to 0 during DWELL -> after the next accepted beat FSM returns to IDLE, sweep_done=0.
  - NCH=5 manual mode with sel=6 -> out_data=0, out_ch=6.
